// File: rtl/partial_sum_acc.sv
// partial_sum_acc: block accumulator for signed 4-bit I/Q correlator products.
// Sums 8/16/32 samples (or fewer on an early dump) into 9-bit partial sums and
// holds them in a one-deep valid/ready register for the round-shift stage.

// One accumulator lane: a 9-bit signed running sum of sign-extended samples.
module psa_lane (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       clr,
  input  logic       add,
  input  logic [3:0] smp,
  output logic [8:0] sum_nx
);
  logic [8:0] acc_q, acc_d;

  // Running sum including this cycle's sample; the block-end value comes from here.
  always_comb begin
    sum_nx = acc_q + (add ? {{5{smp[3]}}, smp} : 9'd0);
    acc_d  = clr ? 9'd0 : sum_nx;
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) acc_q <= '0;
    else        acc_q <= acc_d;
  end
endmodule

module partial_sum_acc (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       enable,
  input  logic [1:0] acc_len,
  input  logic       sample_valid,
  input  logic [3:0] i_in,
  input  logic [3:0] q_in,
  input  logic       dump_req,
  input  logic       sum_ready,
  output logic       sum_valid,
  output logic [8:0] i_sum,
  output logic [8:0] q_sum,
  output logic [1:0] sum_shift,
  output logic [5:0] sum_count,
  output logic       overflow,
  input  logic       overflow_clr
);
  localparam int LANES = 2;  // lane 0 = I, lane 1 = Q

  logic                  accept, blk_end, clr;
  logic [1:0]            cur_len;
  logic [5:0]            target, cnt_inc;
  logic [5:0]            cnt_q, cnt_d;
  logic [1:0]            blk_len_q, blk_len_d;
  logic [LANES-1:0][3:0] smp;
  logic [LANES-1:0][8:0] sum_nx;

  logic                  sv_q, sv_d;
  logic                  ovf_q, ovf_d;
  logic [LANES-1:0][8:0] osum_q, osum_d;
  logic [1:0]            oshift_q, oshift_d;
  logic [5:0]            ocnt_q, ocnt_d;

  assign smp = {q_in, i_in};

  // Block control: the length code is captured with the first sample so that
  // acc_len changes mid-block are ignored; a dump with an empty block is dropped.
  always_comb begin
    accept  = enable & sample_valid;
    cur_len = (cnt_q == 6'd0) ? acc_len : blk_len_q;
    case (cur_len)
      2'd1:    target = 6'd16;
      2'd2:    target = 6'd32;
      default: target = 6'd8;
    endcase
    cnt_inc = cnt_q + {5'd0, accept};
    blk_end = enable & ((accept & (cnt_inc == target)) |
                        (dump_req & (cnt_inc != 6'd0)));
    clr     = ~enable | blk_end;
    cnt_d     = clr ? 6'd0 : cnt_inc;
    blk_len_d = (accept && cnt_q == 6'd0) ? acc_len : blk_len_q;
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      psa_lane u_lane (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (clr),
        .add    (accept),
        .smp    (smp[g]),
        .sum_nx (sum_nx[g])
      );
    end
  endgenerate

  // Output register and handshake: a new block always wins; overwriting an
  // untaken sum raises the sticky overflow, which beats a same-cycle clear.
  always_comb begin
    osum_d   = osum_q;
    oshift_d = oshift_q;
    ocnt_d   = ocnt_q;
    sv_d     = sv_q & ~sum_ready;
    ovf_d    = ovf_q & ~overflow_clr;
    if (blk_end) begin
      osum_d   = sum_nx;
      oshift_d = cur_len;
      ocnt_d   = cnt_inc;
      sv_d     = 1'b1;
      if (sv_q && !sum_ready) ovf_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q    <= '0;
      blk_len_q <= '0;
      sv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      osum_q   <= '0;
      oshift_q <= '0;
      ocnt_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      blk_len_q <= blk_len_d;
      sv_q     <= sv_d;
      ovf_q    <= ovf_d;
      osum_q   <= osum_d;
      oshift_q <= oshift_d;
      ocnt_q   <= ocnt_d;
    end
  end

  assign sum_valid = sv_q;
  assign i_sum     = osum_q[0];
  assign q_sum     = osum_q[1];
  assign sum_shift = oshift_q;
  assign sum_count = ocnt_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_partial_sum_acc.sv
// Bench for partial_sum_acc: directed cases plus random traffic, all checked
// cycle by cycle against an integer reference model of block accumulation.
module tb_partial_sum_acc;
  logic       clk = 1'b0;
  logic       rst_b, enable, sample_valid, dump_req, sum_ready, overflow_clr;
  logic [1:0] acc_len;
  logic [3:0] i_in, q_in;
  logic       sum_valid, overflow;
  logic [8:0] i_sum, q_sum;
  logic [1:0] sum_shift;
  logic [5:0] sum_count;

  int n_tests = 0, n_fail = 0;

  // reference model state (plain integers)
  int m_si, m_sq, m_cnt, m_len;
  int e_valid, e_i, e_q, e_shift, e_cnt, e_ovf;

  partial_sum_acc dut (
    .clk(clk), .rst_b(rst_b), .enable(enable), .acc_len(acc_len),
    .sample_valid(sample_valid), .i_in(i_in), .q_in(q_in),
    .dump_req(dump_req), .sum_ready(sum_ready), .sum_valid(sum_valid),
    .i_sum(i_sum), .q_sum(q_sum), .sum_shift(sum_shift),
    .sum_count(sum_count), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_si = 0; m_sq = 0; m_cnt = 0; m_len = 0;
    e_valid = 0; e_i = 0; e_q = 0; e_shift = 0; e_cnt = 0; e_ovf = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_valid"}, int'(sum_valid), e_valid);
    chk({tag, "_isum"},  int'($signed(i_sum)), e_i);
    chk({tag, "_qsum"},  int'($signed(q_sum)), e_q);
    chk({tag, "_shift"}, int'(sum_shift), e_shift);
    chk({tag, "_count"}, int'(sum_count), e_cnt);
    chk({tag, "_ovf"},   int'(overflow), e_ovf);
  endtask

  // One clock: drive inputs, advance the model, clock, compare everything.
  task automatic cyc(input string tag, input logic en, input logic sv,
                     input logic [1:0] len, input logic [3:0] ii,
                     input logic [3:0] qq, input logic dmp, input logic rdy,
                     input logic clr);
    int tgt;
    bit acc, done;
    enable = en; sample_valid = sv; acc_len = len; i_in = ii; q_in = qq;
    dump_req = dmp; sum_ready = rdy; overflow_clr = clr;
    acc = en && sv;
    if (acc) begin
      if (m_cnt == 0) m_len = int'(len);
      m_si += int'($signed(ii));
      m_sq += int'($signed(qq));
      m_cnt++;
    end
    tgt = (m_len == 1) ? 16 : (m_len == 2) ? 32 : 8;
    done = en && ((acc && m_cnt == tgt) || (dmp && m_cnt > 0));
    if (done) begin
      if (e_valid == 1 && !rdy) e_ovf = 1;
      else if (clr) e_ovf = 0;
      e_valid = 1; e_i = m_si; e_q = m_sq; e_shift = m_len; e_cnt = m_cnt;
    end else begin
      if (rdy) e_valid = 0;
      if (clr) e_ovf = 0;
    end
    if (!en || done) begin m_si = 0; m_sq = 0; m_cnt = 0; end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    model_reset();
    rst_b = 1'b0; enable = 0; sample_valid = 0; acc_len = 0; i_in = 0; q_in = 0;
    dump_req = 0; sum_ready = 0; overflow_clr = 0;
    #2;
    chk_all("reset");
    #10 rst_b = 1'b1;  // t=12, away from the edge

    // 8 x (+7, -8): i=56, q=-64, shift 0, count 8
    for (int k = 0; k < 8; k++) cyc("t1", 1, 1, 2'd0, 4'd7, 4'h8, 0, 1, 0);
    chk("t1_i56", int'($signed(i_sum)), 56);
    chk("t1_qm64", int'($signed(q_sum)), -64);
    chk("t1_cnt8", int'(sum_count), 8);
    cyc("t1_idle", 1, 0, 2'd0, 4'd0, 4'd0, 0, 1, 0);

    // 32 x (-8, +7), acc_len flipped to 0 after sample 5
    for (int k = 0; k < 32; k++)
      cyc("t2", 1, 1, (k < 5) ? 2'd2 : 2'd0, 4'h8, 4'd7, 0, 1, 0);
    chk("t2_i", int'(i_sum), 9'h100);
    chk("t2_q", int'($signed(q_sum)), 224);
    chk("t2_cnt", int'(sum_count), 32);
    chk("t2_shift", int'(sum_shift), 2);

    // 5 x +1 with dump on the 5th, then a dump on an empty block
    for (int k = 0; k < 5; k++) cyc("t3", 1, 1, 2'd1, 4'd1, 4'd0, k == 4, 1, 0);
    chk("t3_i5", int'($signed(i_sum)), 5);
    chk("t3_cnt5", int'(sum_count), 5);
    chk("t3_sh1", int'(sum_shift), 1);
    cyc("t3_take", 1, 0, 2'd1, 4'd0, 4'd0, 0, 1, 0);
    cyc("t3_empty", 1, 0, 2'd1, 4'd0, 4'd0, 1, 1, 0);
    chk("t3_novalid", int'(sum_valid), 0);

    // overwrite with ready low, clear, then load in a transfer cycle
    for (int k = 0; k < 8; k++) cyc("t4a", 1, 1, 2'd0, 4'd1, 4'd0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc("t4b", 1, 1, 2'd0, 4'd2, 4'd0, 0, 0, 0);
    chk("t4_i16", int'($signed(i_sum)), 16);
    chk("t4_ovf", int'(overflow), 1);
    cyc("t4_clr", 1, 0, 2'd0, 4'd0, 4'd0, 0, 0, 1);
    chk("t4_ovf0", int'(overflow), 0);
    for (int k = 0; k < 8; k++) cyc("t4c", 1, 1, 2'd0, 4'd3, 4'd0, 0, k == 7, 0);
    chk("t4_noovf", int'(overflow), 0);
    chk("t4_valid", int'(sum_valid), 1);

    // enable drop discards a partial block
    for (int k = 0; k < 3; k++) cyc("t5a", 1, 1, 2'd0, 4'd5, 4'd1, 0, 1, 0);
    cyc("t5_off", 0, 1, 2'd0, 4'd5, 4'd1, 1, 1, 0);
    for (int k = 0; k < 8; k++) cyc("t5b", 1, 1, 2'd0, 4'd3, 4'd0, 0, 1, 0);
    chk("t5_i24", int'($signed(i_sum)), 24);
    chk("t5_cnt8", int'(sum_count), 8);

    // asynchronous reset mid-block with a sum pending
    for (int k = 0; k < 11; k++) cyc("t6", 1, 1, 2'd0, 4'd2, 4'd6, 0, 0, 0);
    #2 rst_b = 1'b0;
    #1;
    model_reset();
    chk_all("t6_rst");
    #2 rst_b = 1'b1;

    // random traffic
    for (int k = 0; k < 3000; k++)
      cyc("rnd", $urandom_range(0, 19) != 0, $urandom_range(0, 9) < 7,
          2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
          $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 19) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/partial_sum_acc.md
# partial_sum_acc

Accumulates signed 4-bit I/Q correlator products over 8, 16 or 32 samples and presents the 9-bit partial sums, with the matching shift code, to the unbiased round-shift stage directly downstream. The shift stage then scales each sum to 6 bits. The block sits inside each correlator channel, between the carrier/code-wipeoff multiplier and the round-shift/coherent-sum path. It owns block counting, early dump at epoch boundaries and a one-deep valid/ready output register.

## Interface
- none (widths fixed: 4-bit samples, 9-bit sums, 2-bit shift code)

- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- enable  in  1  channel active; low clears accumulators and sample count
- acc_len  in  2  block length code: 0→8, 1→16, 2→32, 3→8 samples
- sample_valid  in  1  i_in/q_in valid this cycle
- i_in, q_in  in  4 each  signed two's-complement products
- dump_req  in  1  end the current block early; emit the partial sum
- sum_ready  in  1  downstream accepts output this cycle
- sum_valid  out  1  output register holds an untaken sum
- i_sum, q_sum  out  9 each  signed accumulated sums
- sum_shift  out  2  acc_len code latched at block start; feeds round-shift shift_bits
- sum_count  out  6  number of samples in the sum, 1..32
- overflow  out  1  sticky; a sum was overwritten before it was taken
- overflow_clr  in  1  clears overflow

## Operation
- States: IDLE (enable=0) and ACC (enable=1). IDLE holds acc_i, acc_q and cnt at 0 and ignores sample_valid and dump_req.
- ACC, sample accepted (sample_valid=1):
  - Sign-extend the inputs to 9 bits and add them to acc_i and acc_q.
  - Increment cnt.
  - If cnt was 0, latch acc_len into blk_len. Changes to acc_len mid-block have no effect.
- Target: 8/16/32 from blk_len (code 3→8).
- Block end: the accepted sample makes cnt+1 equal the target, OR dump_req=1 while cnt+accepted ≥ 1.
  - Load the output registers with acc+sample, blk_len and cnt+1 (or cnt with no sample).
  - Clear acc and cnt in the same edge.
- dump_req with cnt=0 and no sample: ignored, no output. dump_req together with a sample: the sample is included, then the block is dumped. Natural end and dump_req in the same cycle: exactly one output.
- Range: 32 × (−8) = −256 and 32 × 7 = 224, so both fit 9 bits signed. No saturation and no wrap is possible.
- Output handshake:
  - Transfer happens when sum_valid & sum_ready.
  - A load with sum_valid=0, or in the transfer cycle: sum_valid=1 with the new data, no overflow.
  - A load with sum_valid=1 and sum_ready=0: the new data overwrites the old, sum_valid stays 1, overflow is set.
  - Transfer with no load: sum_valid=0. Data registers hold their last value.
- overflow: set has priority over overflow_clr in the same cycle.
- enable 1→0: acc and cnt clear on the next edge, and an in-progress block is discarded. The output register and its handshake are unaffected, so a pending sum can still drain.
- enable 0→1: the first accepted sample starts a new block.

## Timing
- Reset (rst_b=0, async): sum_valid=0, i_sum=q_sum=0, sum_shift=0, sum_count=0, overflow=0, internal acc/cnt/blk_len=0.
- Latency: final sample at edge N → sum_valid=1 and data valid after edge N (registered). Nothing combinational from inputs to outputs.
- Back-to-back blocks with no idle cycle are supported: the sample after the final one goes into the fresh accumulator.
- Throughput: one sample per clock.
- Reset mid-block: all state clears immediately; no partial output.

## Test plan
- acc_len=0, 8 samples i=+7, q=−8, sum_ready=1 → one pulse: i_sum=56, q_sum=−64, sum_shift=0, sum_count=8, one cycle after the 8th sample.
- acc_len=2, 32 samples i=−8, q=+7 → i_sum=−256 (9'h100), q_sum=224, sum_count=32, sum_shift=2. Change acc_len to 0 after sample 5 → still 32 samples.
- acc_len=1, 5 samples i=+1, dump_req on the 5th sample → i_sum=5, sum_count=5, sum_shift=1. Next block starts at 0. dump_req with cnt=0 → no output.
- sum_ready=0, two consecutive 8-sample blocks (i=1, then i=2) → after the second: i_sum=16, sum_valid=1, overflow=1. overflow_clr → 0. Load in the transfer cycle → no overflow.
- enable dropped after 3 samples, then raised, then 8 samples of i=+3 → i_sum=24, sum_count=8. Assert rst_b=0 mid-block → all outputs 0 asynchronously.
- Random samples and acc_len with random sum_ready against a reference model → sums, counts and overflow match on every transfer.
